// File: rtl/conv2_pkg.sv
// Shared definitions for the conv2 feeder: FSM states, window-count helpers, pipe latency.
// CONV2_FEEDER_ZERO_PAD_EN selects the 1-pixel zero-border geometry.
package conv2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGap,
    StDrain,
    StWaitAck,
    StDone
  } state_e;

  // Cycles from a tap's read request until it is presented on pix_out.
  localparam int unsigned PipeLat = 2;

  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k);
`ifdef CONV2_FEEDER_ZERO_PAD_EN
    return in_dim + 2 - k + 1;
`else
    return in_dim - k + 1;
`endif
  endfunction

  function automatic int unsigned num_win(input int unsigned w, input int unsigned h,
                                          input int unsigned k);
    return out_dim(w, k) * out_dim(h, k);
  endfunction

endpackage

// File: rtl/conv2_addr_gen.sv
// Window/tap counters and frame-buffer address generation for the conv2 feeder.
// With CONV2_FEEDER_ZERO_PAD_EN, also flags taps that fall on the zero border.
module conv2_addr_gen
  import conv2_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IN_W        = 32,
  parameter int unsigned IN_H        = 44,
  parameter int unsigned ADDR_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  tap_adv,
  input  logic                  row_adv,
  input  logic                  win_adv,
  output logic                  c_last,
  output logic                  r_last,
  output logic [ADDR_WIDTH-1:0] fm_addr,
  output logic [3:0]            w_addr,
  output logic                  pad
);

  localparam int unsigned OutW = out_dim(IN_W, KERNEL_SIZE);
  localparam logic [ADDR_WIDTH-1:0] RowStep = ADDR_WIDTH'(IN_W);
  localparam logic [ADDR_WIDTH-1:0] WinRows = ADDR_WIDTH'((KERNEL_SIZE - 1) * IN_W);
  localparam logic [ADDR_WIDTH-1:0] XLast   = ADDR_WIDTH'(OutW - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [3:0]            KLast   = 4'(KERNEL_SIZE - 1);

  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;  // (y + r) * IN_W
  logic [3:0]            r_q, r_d, c_q, c_d, tap_q, tap_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  pad_raw;

  assign c_last = (c_q == KLast);
  assign r_last = (r_q == KLast);

`ifdef CONV2_FEEDER_ZERO_PAD_EN
  logic [ADDR_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0] col_p, row_p;

  // Coordinates in the padded map; column/row 0 and IN_W+1/IN_H+1 are border.
  assign col_p   = x_q + ADDR_WIDTH'(c_q);
  assign row_p   = y_q + ADDR_WIDTH'(r_q);
  assign pad_raw = (col_p == '0) || (col_p > RowStep) ||
                   (row_p == '0) || (row_p > ADDR_WIDTH'(IN_H));
  assign addr    = row_base_q - RowStep + x_q + ADDR_WIDTH'(c_q) - AddrOne;

  always_comb begin
    y_d = y_q;
    if (clear) begin
      y_d = '0;
    end else if (win_adv && (x_q == XLast)) begin
      y_d = y_q + AddrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end
`else
  assign pad_raw = 1'b0;
  assign addr    = row_base_q + x_q + ADDR_WIDTH'(c_q);
`endif

  always_comb begin
    x_d        = x_q;
    row_base_d = row_base_q;
    r_d        = r_q;
    c_d        = c_q;
    tap_d      = tap_q;
    if (clear) begin
      x_d        = '0;
      row_base_d = '0;
      r_d        = '0;
      c_d        = '0;
      tap_d      = '0;
    end else begin
      if (tap_adv) begin
        c_d   = c_last ? 4'd0 : c_q + 4'd1;
        tap_d = tap_q + 4'd1;
      end
      if (row_adv) begin
        if (r_last) begin
          // Window finished: rewind to the window's top row.
          r_d        = '0;
          tap_d      = '0;
          row_base_d = row_base_q - WinRows;
        end else begin
          r_d        = r_q + 4'd1;
          row_base_d = row_base_q + RowStep;
        end
      end
      if (win_adv) begin
        if (x_q == XLast) begin
          x_d        = '0;
          row_base_d = row_base_q + RowStep;
        end else begin
          x_d = x_q + AddrOne;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      row_base_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
      tap_q      <= '0;
    end else begin
      x_q        <= x_d;
      row_base_q <= row_base_d;
      r_q        <= r_d;
      c_q        <= c_d;
      tap_q      <= tap_d;
    end
  end

  assign pad     = tap_adv && pad_raw;
  assign fm_addr = (tap_adv && !pad_raw) ? addr : '0;
  assign w_addr  = tap_adv ? tap_q : '0;

endmodule

// File: rtl/conv2_feeder.sv
// conv2 feeder top: window-scan FSM, early-ack latch, two-stage output pipe, window counter.
// Build with CONV2_FEEDER_ZERO_PAD_EN for the 1-pixel zero-border scan.
module conv2_feeder
  import conv2_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned OUT_CH       = 16,
  parameter int unsigned IN_W         = 32,
  parameter int unsigned IN_H         = 44,
  parameter int unsigned ADDR_WIDTH   = 11
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             fm_rd,
  output logic [ADDR_WIDTH-1:0]            fm_addr,
  input  logic [DATA_WIDTH-1:0]            fm_data,
  output logic                             w_rd,
  output logic [3:0]                       w_addr,
  input  logic [WEIGHT_WIDTH*OUT_CH-1:0]   w_data,
  input  logic                             win_ack,
  output logic [DATA_WIDTH-1:0]            pix_out,
  output logic                             valid,
  output logic [WEIGHT_WIDTH*OUT_CH-1:0]   c2_w,
  output logic                             c2_w_en,
  output logic                             busy,
  output logic                             done,
  output logic [10:0]                      win_cnt
);

  localparam int unsigned   NumWin    = num_win(IN_W, IN_H, KERNEL_SIZE);
  localparam logic [10:0]   WinLast   = 11'(NumWin - 1);
  localparam logic [1:0]    DrainLast = 2'(PipeLat - 1);

  state_e      state_q, state_d;
  logic        ack_pend_q, ack_pend_d;
  logic [10:0] win_cnt_q, win_cnt_d;
  logic [1:0]  drain_q, drain_d;
  logic        clear, ack_take, issue, c_last, r_last, pad;

  logic                           rd_q, pad_q, valid_q;
  logic [DATA_WIDTH-1:0]          pix_q;
  logic [WEIGHT_WIDTH*OUT_CH-1:0] w_q;

  assign issue = (state_q == StIssue);

  conv2_addr_gen #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .IN_W        (IN_W),
    .IN_H        (IN_H),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .tap_adv (issue),
    .row_adv (state_q == StGap),
    .win_adv (ack_take),
    .c_last  (c_last),
    .r_last  (r_last),
    .fm_addr (fm_addr),
    .w_addr  (w_addr),
    .pad     (pad)
  );

  always_comb begin
    state_d    = state_q;
    ack_pend_d = ack_pend_q;
    win_cnt_d  = win_cnt_q;
    drain_d    = '0;
    clear      = 1'b0;
    ack_take   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StIssue;
          clear      = 1'b1;
          win_cnt_d  = '0;
          ack_pend_d = 1'b0;
        end
      end
      StIssue: begin
        if (c_last) state_d = StGap;
      end
      StGap: begin
        state_d = r_last ? StDrain : StIssue;
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StWaitAck;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StWaitAck: begin
        // A live ack arriving while one is already latched counts only once.
        if (ack_pend_q || win_ack) begin
          ack_take   = 1'b1;
          ack_pend_d = 1'b0;
          win_cnt_d  = win_cnt_q + 11'd1;
          state_d    = (win_cnt_q == WinLast) ? StDone : StIssue;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (win_ack && (state_q inside {StIssue, StGap, StDrain})) begin
      ack_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ack_pend_q <= 1'b0;
      win_cnt_q  <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_pend_q <= ack_pend_d;
      win_cnt_q  <= win_cnt_d;
      drain_q    <= drain_d;
    end
  end

  // Stage 1 tracks the outstanding read; stage 2 captures the returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      pad_q   <= 1'b0;
      valid_q <= 1'b0;
      pix_q   <= '0;
      w_q     <= '0;
    end else begin
      rd_q    <= issue;
      pad_q   <= pad;
      valid_q <= rd_q;
      if (rd_q) begin
        pix_q <= pad_q ? '0 : fm_data;
        w_q   <= w_data;
      end
    end
  end

  assign fm_rd   = issue && !pad;
  assign w_rd    = issue;
  assign pix_out = pix_q;
  assign c2_w    = w_q;
  assign valid   = valid_q;
  assign c2_w_en = valid_q;
  assign busy    = (state_q != StIdle) && (state_q != StDone);
  assign done    = (state_q == StDone);
  assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_conv2_feeder.sv
// Self-checking bench for conv2_feeder: tap-stream reference model, randomized ack timing,
// spot-check table, reset and start corner cases. Honours CONV2_FEEDER_ZERO_PAD_EN.
module tb_conv2_feeder;

  localparam int K = 3, DW = 8, WW = 8, OC = 16, IW = 32, IH = 44, AW = 11;
  localparam int WORD = WW * OC;
`ifdef CONV2_FEEDER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int OW = PAD ? IW : IW - K + 1;
  localparam int OH = PAD ? IH : IH - K + 1;
  localparam int NW = OW * OH;
  localparam int TPW = K * K;

  logic            clk = 1'b0, rst_n, start, win_ack;
  logic            fm_rd, w_rd, valid, c2_w_en, busy, done;
  logic [AW-1:0]   fm_addr;
  logic [3:0]      w_addr;
  logic [DW-1:0]   fm_data = '0, pix_out;
  logic [WORD-1:0] w_data = '0, c2_w;
  logic [10:0]     win_cnt;

  conv2_feeder #(
    .KERNEL_SIZE (K), .DATA_WIDTH (DW), .WEIGHT_WIDTH (WW), .OUT_CH (OC),
    .IN_W (IW), .IN_H (IH), .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .fm_rd (fm_rd), .fm_addr (fm_addr), .fm_data (fm_data),
    .w_rd (w_rd), .w_addr (w_addr), .w_data (w_data),
    .win_ack (win_ack), .pix_out (pix_out), .valid (valid),
    .c2_w (c2_w), .c2_w_en (c2_w_en), .busy (busy), .done (done), .win_cnt (win_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD-1:0] wword(input int a);
    logic [WORD-1:0] w;
    for (int n = 0; n < OC; n++) w[n*WW +: WW] = WW'(a * 16 + n + 1);
    return w;
  endfunction

  // Sync-read memories: fm[i] = i % 128, weights derived from tap index.
  always @(posedge clk) if (fm_rd) fm_data <= DW'(fm_addr % 128);
  always @(posedge clk) if (w_rd) w_data <= wword(int'(w_addr));

  // Reference: window k in raster order, tap t = r*K + c.
  function automatic void exp_tap(input int k, input int t, output bit pd, output int addr,
                                  output logic [DW-1:0] px);
    int x, y, col, row;
    x   = k % OW;
    y   = k / OW;
    col = x + t % K - (PAD ? 1 : 0);
    row = y + t / K - (PAD ? 1 : 0);
    pd   = (col < 0) || (col >= IW) || (row < 0) || (row >= IH);
    addr = pd ? 0 : row * IW + col;
    px   = pd ? '0 : DW'(addr % 128);
  endfunction

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int cyc = 0, iss_n = 0, out_n = 0, done_cnt = 0, ack_d = 0;
  int first_vcyc = 0, last_vcyc = 0;
  logic [1:0] hist = '0;
  int first_addr[NW];
  logic [DW-1:0] pix0[TPW];

  // Monitor: every cycle, checked on the falling edge.
  initial begin
    bit pd;
    int ea, k, t;
    logic [DW-1:0] ep;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hist = '0;
      end else begin
        if (start && !busy && !done) begin
          iss_n = 0;
          out_n = 0;
          done_cnt = 0;
        end
        chk("c2_w_en_eq_valid", c2_w_en, valid);
        chk("valid_latency", valid, hist[1]);
        if (w_rd) begin
          k = iss_n / TPW;
          t = iss_n % TPW;
          exp_tap(k, t, pd, ea, ep);
          chk("fm_rd", fm_rd, !pd);
          if (!pd) chk("fm_addr", fm_addr, ea);
          chk("w_addr", w_addr, t);
          if (t == 0 && k < NW) first_addr[k] = int'(fm_addr);
          if (t == 0 && k > 0) chk("ack_to_issue", cyc - last_vcyc, (ack_d > 1) ? 2 + ack_d : 3);
          iss_n++;
        end else begin
          chk("fm_rd_idle", fm_rd, 0);
        end
        if (valid) begin
          k = out_n / TPW;
          t = out_n % TPW;
          exp_tap(k, t, pd, ea, ep);
          chk("pix_out", pix_out, ep);
          chk("c2_w", c2_w, wword(t));
          if (out_n < TPW) pix0[out_n] = pix_out;
          if (t == 0) begin
            chk("win_cnt_at_window", win_cnt, k);
            first_vcyc = cyc;
          end
          if (t == TPW - 1) begin
            chk("window_span", cyc - first_vcyc, K * (K + 1) - 2);
            last_vcyc = cyc;
          end
          out_n++;
        end
        if (done) done_cnt++;
        hist = {hist[0], w_rd};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int kind;  // 0: window-0 pixel at tap, 1: first fm_addr of window
    int win;
    int tap;
    int exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int kind, input int win, input int tap, input int exp);
    vec_t v;
    v.kind = kind; v.win = win; v.tap = tap; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_out(input int target, output bit ok);
    int n = 0;
    while (out_n < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    ok = (out_n >= target);
    chk("wait_window_taps", ok, 1);
  endtask

  // Ack window k, d cycles after the cycle following its last valid tap.
  task automatic ack_window(input int k, input int d, input bit dup, output bit ok);
    wait_out(TPW * (k + 1), ok);
    if (!ok) return;
    ack_d = d;
    repeat (d) @(posedge clk);
    #1 win_ack = 1'b1;
    @(posedge clk);
    #1 win_ack = dup;
    if (dup) begin
      @(posedge clk);
      #1 win_ack = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int d, act;
    rst_n = 1'b0; start = 1'b0; win_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fm_rd", fm_rd, 0);
    chk("rst_w_rd", w_rd, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_c2_w", c2_w, 0);
    chk("rst_win_cnt", win_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    win_ack = 1'b1;  // ignored while idle
    @(posedge clk); #1 win_ack = 1'b0;
    chk("idle_busy", busy, 0);

    if (PAD) begin
      add(0, 0, 0, 0);  add(0, 0, 1, 0);  add(0, 0, 2, 0);
      add(0, 0, 3, 0);  add(0, 0, 4, 0);  add(0, 0, 5, 1);
      add(0, 0, 6, 0);  add(0, 0, 7, 32); add(0, 0, 8, 33);
      add(1, 33, 0, 0); add(1, 1407, 0, 1374);
    end else begin
      add(0, 0, 0, 0);  add(0, 0, 1, 1);  add(0, 0, 2, 2);
      add(0, 0, 3, 32); add(0, 0, 4, 33); add(0, 0, 5, 34);
      add(0, 0, 6, 64); add(0, 0, 7, 65); add(0, 0, 8, 66);
      add(1, 0, 0, 0);  add(1, 29, 0, 29); add(1, 30, 0, 32);
      add(1, 31, 0, 33); add(1, 1259, 0, 1341);
    end

    // Full frame with random ack timing, early and duplicate acks.
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < NW; k++) begin
      if (k == 10) pulse_start();  // must be ignored mid-frame
      d = (k == NW - 1) ? 2 : $urandom_range(0, 4);
      ack_window(k, d, (d == 0) && ($urandom_range(0, 2) == 0), ok);
      if (!ok) break;
    end
    #1 start = 1'b1;  // coincides with the DONE cycle
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("start_in_done_ignored", busy, 0);
    chk("done_pulses", done_cnt, 1);
    chk("frame_win_cnt", win_cnt, NW);
    chk("frame_taps", out_n, NW * TPW);

    foreach (tbl[i]) begin
      act = (tbl[i].kind == 0) ? int'(pix0[tbl[i].tap]) : first_addr[tbl[i].win];
      chk($sformatf("table[%0d] kind%0d win%0d tap%0d", i, tbl[i].kind, tbl[i].win, tbl[i].tap),
          act, tbl[i].exp);
    end

    // Reset mid-frame at window 500, tap 4.
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      ack_window(k, $urandom_range(0, 3), 1'b0, ok);
      if (!ok) break;
    end
    for (int n = 0; n < 100 && iss_n < 500 * TPW + 4; n++) @(posedge clk);
    #2;
    chk("mid_tap_w_rd", w_rd, 1);
    chk("mid_tap_w_addr", w_addr, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_fm_rd", fm_rd, 0);
    chk("arst_w_rd", w_rd, 0);
    chk("arst_fm_addr", fm_addr, 0);
    chk("arst_valid", valid, 0);
    chk("arst_c2_w_en", c2_w_en, 0);
    chk("arst_pix_out", pix_out, 0);
    chk("arst_c2_w", c2_w, 0);
    chk("arst_busy", busy, 0);
    chk("arst_win_cnt", win_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start();
    chk("restart_win_cnt", win_cnt, 0);
    ack_window(0, 1, 1'b0, ok);
    chk("restart_first_addr", first_addr[0], 0);
    chk("restart_first_pix", pix0[TPW - 1], PAD ? 33 : 66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
